// File: rtl/random_pkg.sv
// Shared constants and types for the multi-channel random pulse generator.
package random_pkg;

    localparam logic [31:0] DEFAULT_TAPS = 32'h80200003;
    localparam logic [31:0] DEFAULT_SEED = 32'hAAAAAAAA;

    localparam logic MODE_RAW    = 1'b0;
    localparam logic MODE_SHAPED = 1'b1;

    typedef enum logic [1:0] {
        SH_IDLE,
        SH_HIGH,
        SH_DEAD
    } shaper_state_e;

endpackage

// File: rtl/pulse_shaper.sv
// One output channel: threshold compare on its LFSR view, raw or shaped pulse,
// and a saturating trigger counter.
module pulse_shaper
    import random_pkg::*;
#(
    parameter int LFSR_W   = 32,
    parameter int THRESH_W = 8,
    parameter int SHIFT    = 12,
    parameter int LEN_W    = 8,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_i,
    input  logic                mode_i,
    input  logic [LFSR_W-1:0]   view_i,
    input  logic [THRESH_W-1:0] thresh_i,
    input  logic [LEN_W-1:0]    pulse_len_i,
    input  logic [LEN_W-1:0]    dead_time_i,
    input  logic                cnt_clear_i,
    output logic                pulse_o,
    output logic [CNT_W-1:0]    cnt_o
);

    shaper_state_e     state_q, state_d;
    logic [LEN_W-1:0]  ctr_q, ctr_d;
    logic              pulse_q, pulse_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LFSR_W-1:0] level;
    logic              hit;
    logic              trigger;

    // A zero threshold gives a zero level, which no view can be below.
    assign level = LFSR_W'(thresh_i) << SHIFT;
    assign hit   = enable_i && (view_i < level);

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        pulse_d = pulse_q;
        trigger = 1'b0;
        unique case (state_q)
            SH_IDLE: begin
                ctr_d = '0;
                case (mode_i)
                    MODE_RAW: begin
                        pulse_d = hit;
                        trigger = hit;
                    end
                    MODE_SHAPED: begin
                        pulse_d = 1'b0;
                        if (hit) begin
                            state_d = SH_HIGH;
                            pulse_d = 1'b1;
                            trigger = 1'b1;
                            ctr_d   = (pulse_len_i == '0) ? '0 : pulse_len_i - 1'b1;
                        end
                    end
                endcase
            end
            SH_HIGH: begin
                if (ctr_q != '0) begin
                    ctr_d = ctr_q - 1'b1;
                end else begin
                    pulse_d = 1'b0;
                    if (dead_time_i != '0) begin
                        state_d = SH_DEAD;
                        ctr_d   = dead_time_i - 1'b1;
                    end else begin
                        state_d = SH_IDLE;
                    end
                end
            end
            SH_DEAD: begin
                pulse_d = 1'b0;
                if (ctr_q != '0) begin
                    ctr_d = ctr_q - 1'b1;
                end else begin
                    state_d = SH_IDLE;
                end
            end
            default: begin
                state_d = SH_IDLE;
                ctr_d   = '0;
                pulse_d = 1'b0;
            end
        endcase
    end

    // A clear coinciding with a trigger still records that trigger.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clear_i) begin
            cnt_d = trigger ? CNT_W'(1) : '0;
        end else if (trigger && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SH_IDLE;
            ctr_q   <= '0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse_o = pulse_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/random_pulser_multi.sv
// Multi-channel pseudo-random pulse source: one shared Fibonacci LFSR, each
// channel looking at its own rotation of the state.
module random_pulser_multi
    import random_pkg::*;
#(
    parameter int                LFSR_W    = 32,
    parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(DEFAULT_TAPS),
    parameter logic [LFSR_W-1:0] SEED_INIT = LFSR_W'(DEFAULT_SEED),
    parameter int                NCH       = 4,
    parameter int                THRESH_W  = 8,
    parameter int                SHIFT     = 12,
    parameter int                LEN_W     = 8,
    parameter int                CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    mode,
    input  logic                    seed_load,
    input  logic [LFSR_W-1:0]       seed,
    input  logic [NCH*THRESH_W-1:0] thresh,
    input  logic [LEN_W-1:0]        pulse_len,
    input  logic [LEN_W-1:0]        dead_time,
    input  logic                    cnt_clear,
    output logic [NCH-1:0]          pulse,
    output logic [NCH*CNT_W-1:0]    pulse_cnt,
    output logic [LFSR_W-1:0]       lfsr_state
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic              fb;

    assign fb = ^(lfsr_q & TAPS);

    // Seed loading wins over advancing; an all-zero seed would lock the LFSR.
    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load) begin
            lfsr_d = (seed == '0) ? SEED_INIT : seed;
        end else if (enable) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED_INIT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_state = lfsr_q;

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        localparam int ROT = (ch * (LFSR_W / NCH)) % LFSR_W;
        logic [LFSR_W-1:0] view;

        if (ROT == 0) begin : g_norot
            assign view = lfsr_q;
        end else begin : g_rot
            assign view = {lfsr_q[LFSR_W-ROT-1:0], lfsr_q[LFSR_W-1:LFSR_W-ROT]};
        end

        pulse_shaper #(
            .LFSR_W   (LFSR_W),
            .THRESH_W (THRESH_W),
            .SHIFT    (SHIFT),
            .LEN_W    (LEN_W),
            .CNT_W    (CNT_W)
        ) u_shaper (
            .clk         (clk),
            .reset       (reset),
            .enable_i    (enable),
            .mode_i      (mode),
            .view_i      (view),
            .thresh_i    (thresh[ch*THRESH_W +: THRESH_W]),
            .pulse_len_i (pulse_len),
            .dead_time_i (dead_time),
            .cnt_clear_i (cnt_clear),
            .pulse_o     (pulse[ch]),
            .cnt_o       (pulse_cnt[ch*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_random_pulser_multi.sv
// Randomised bench for random_pulser_multi against a cycle-level behavioural model
// of pulse timing, counters and the LFSR sequence.
module tb_random_pulser_multi;

    localparam int          LW     = 32;
    localparam int          NCH    = 4;
    localparam int          TW     = 8;
    localparam int          SHIFT  = 24;
    localparam int          LEN_W  = 8;
    localparam int          CNT_W  = 4;
    localparam int          CNTMAX = 15;
    localparam logic [31:0] TAPS_M = 32'h80200003;
    localparam logic [31:0] SEED_M = 32'hAAAAAAAA;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        mode;
    logic        seed_load;
    logic [31:0] seed;
    logic [31:0] thresh;
    logic [7:0]  pulse_len;
    logic [7:0]  dead_time;
    logic        cnt_clear;
    logic [3:0]  pulse;
    logic [15:0] pulse_cnt;
    logic [31:0] lfsr_state;

    int checks = 0;
    int errors = 0;

    // Model: remaining high / dead cycles per channel, idle when both are zero.
    logic [31:0] mLfsr;
    int          mHighLeft [NCH];
    int          mDeadLeft [NCH];
    int          mCnt      [NCH];
    bit          mPulse    [NCH];

    random_pulser_multi #(
        .LFSR_W    (LW),
        .TAPS      (TAPS_M),
        .SEED_INIT (SEED_M),
        .NCH       (NCH),
        .THRESH_W  (TW),
        .SHIFT     (SHIFT),
        .LEN_W     (LEN_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .seed_load  (seed_load),
        .seed       (seed),
        .thresh     (thresh),
        .pulse_len  (pulse_len),
        .dead_time  (dead_time),
        .cnt_clear  (cnt_clear),
        .pulse      (pulse),
        .pulse_cnt  (pulse_cnt),
        .lfsr_state (lfsr_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] rotl(input logic [31:0] x, input int r);
        if (r == 0) return x;
        return (x << r) | (x >> (32 - r));
    endfunction

    function automatic bit modelHit(input int ch);
        longint unsigned view;
        longint unsigned level;
        view  = rotl(mLfsr, ch * (LW / NCH));
        level = thresh[ch*TW +: TW];
        level = level << SHIFT;
        return enable && (view < level);
    endfunction

    function automatic logic [51:0] expVec();
        logic [3:0]  p;
        logic [15:0] c;
        for (int i = 0; i < NCH; i++) begin
            p[i]          = mPulse[i];
            c[i*4 +: 4]   = 4'(mCnt[i]);
        end
        return {mLfsr, p, c};
    endfunction

    task automatic modelReset();
        mLfsr = SEED_M;
        for (int i = 0; i < NCH; i++) begin
            mHighLeft[i] = 0;
            mDeadLeft[i] = 0;
            mCnt[i]      = 0;
            mPulse[i]    = 0;
        end
    endtask

    task automatic modelStep();
        bit h;
        bit trig;
        int parity;
        for (int i = 0; i < NCH; i++) begin
            h    = modelHit(i);
            trig = 0;
            if (mHighLeft[i] > 0) begin
                mHighLeft[i]--;
                if (mHighLeft[i] == 0) begin
                    mPulse[i]    = 0;
                    mDeadLeft[i] = dead_time;
                end
            end else if (mDeadLeft[i] > 0) begin
                mDeadLeft[i]--;
            end else if (mode == 1'b0) begin
                mPulse[i] = h;
                trig      = h;
            end else if (h) begin
                mHighLeft[i] = (pulse_len == 0) ? 1 : int'(pulse_len);
                mPulse[i]    = 1;
                trig         = 1;
            end else begin
                mPulse[i] = 0;
            end
            if (cnt_clear) mCnt[i] = trig ? 1 : 0;
            else if (trig && mCnt[i] < CNTMAX) mCnt[i]++;
        end
        parity = $countones(mLfsr & TAPS_M) % 2;
        if (seed_load) mLfsr = (seed == 0) ? SEED_M : seed;
        else if (enable) mLfsr = (mLfsr << 1) | 32'(parity);
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        enable    = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) mode = ~mode;
        seed_load = ($urandom_range(0, 63) == 0);
        seed      = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
        thresh    = $urandom;
        pulse_len = 8'($urandom_range(0, 4));
        dead_time = 8'($urandom_range(0, 3));
        cnt_clear = ($urandom_range(0, 31) == 0);
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; mode = 1'b0; seed_load = 1'b0; seed = '0;
        thresh = '1; pulse_len = 8'd1; dead_time = 8'd0; cnt_clear = 1'b0;
        modelReset();
        #3;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if ({lfsr_state, pulse, pulse_cnt} !== {SEED_M, 4'h0, 16'h0}) begin
                errors++;
                $display("[TB] FAIL reset_state: got %h required %h",
                         {lfsr_state, pulse, pulse_cnt}, {SEED_M, 4'h0, 16'h0});
            end
        end
        enable = 1'b0; thresh = '0;
        reset  = 1'b1;
    endtask

    task automatic test_lfsr_check();
        enable = 1'b1;
        tick();
        checks++;
        if (lfsr_state !== 32'h55555555) begin
            errors++;
            $display("[TB] FAIL lfsr_first_step: got %h required %h", lfsr_state, 32'h55555555);
        end
        checks++;
        if ({lfsr_state, pulse, pulse_cnt} !== expVec()) begin
            errors++;
            $display("[TB] FAIL lfsr_model: got %h required %h", {lfsr_state, pulse, pulse_cnt}, expVec());
        end
    endtask

    task automatic test_seed_load();
        seed_load = 1'b1; seed = 32'h0; enable = 1'b1;
        tick();
        checks++;
        if (lfsr_state !== SEED_M) begin
            errors++;
            $display("[TB] FAIL seed_zero: got %h required %h", lfsr_state, SEED_M);
        end
        seed = 32'h12345678; enable = 1'b0;
        tick();
        seed_load = 1'b0;
        repeat (3) begin
            checks++;
            if (lfsr_state !== 32'h12345678) begin
                errors++;
                $display("[TB] FAIL seed_hold: got %h required %h", lfsr_state, 32'h12345678);
            end
            tick();
        end
    endtask

    task automatic test_zero_thresh();
        bit diverged = 0;
        thresh = '0; enable = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            mode = 1'($urandom_range(0, 1));
            tick();
            if (!diverged) begin
                checks++;
                if (pulse !== 4'h0 || lfsr_state !== mLfsr) begin
                    errors++; diverged = 1;
                    $display("[TB] FAIL zero_thresh_cycle%0d: pulse %h lfsr %h required pulse 0 lfsr %h",
                             c, pulse, lfsr_state, mLfsr);
                end
            end
        end
        checks++;
        if (pulse_cnt !== 16'h0) begin
            errors++;
            $display("[TB] FAIL zero_thresh_count: got %h required 0000", pulse_cnt);
        end
    endtask

    task automatic test_shaped();
        int  runLen, lowLen, rises;
        bit  prev, cur, diverged;
        mode = 1'b1; thresh = 32'h000000FF; pulse_len = 8'd3; dead_time = 8'd2;
        enable = 1'b0; seed = 32'h1; seed_load = 1'b1; cnt_clear = 1'b1;
        tick();
        seed_load = 1'b0; cnt_clear = 1'b0; enable = 1'b1;
        runLen = 0; lowLen = 0; rises = 0; prev = 0; diverged = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            cur = pulse[0];
            if (!diverged) begin
                checks++;
                if ({lfsr_state, pulse, pulse_cnt} !== expVec()) begin
                    errors++; diverged = 1;
                    $display("[TB] FAIL shaped_model_cycle%0d: got %h required %h",
                             c, {lfsr_state, pulse, pulse_cnt}, expVec());
                end
            end
            if (c == 0) begin
                checks++;
                if (cur !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL shaped_first_pulse: got %b required 1", cur);
                end
            end
            if (cur) runLen++;
            else     lowLen++;
            if (!cur && prev) begin
                checks++;
                if (runLen != 3) begin
                    errors++;
                    $display("[TB] FAIL shaped_width: got %0d required 3", runLen);
                end
                runLen = 0;
            end
            if (cur && !prev) begin
                rises++;
                if (rises > 1) begin
                    checks++;
                    if (lowLen < 2) begin
                        errors++;
                        $display("[TB] FAIL shaped_dead: got %0d low cycles required at least 2", lowLen);
                    end
                end
                lowLen = 0;
            end
            prev = cur;
        end
        checks++;
        if (int'(pulse_cnt[3:0]) != rises) begin
            errors++;
            $display("[TB] FAIL shaped_count: got %0d required %0d", pulse_cnt[3:0], rises);
        end

        enable = 1'b0;
        repeat (10) tick();
        pulse_len = 8'd0; dead_time = 8'd0; enable = 1'b1;
        runLen = 0; prev = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            cur = pulse[0];
            if (cur) runLen++;
            if (!cur && prev) begin
                checks++;
                if (runLen != 1) begin
                    errors++;
                    $display("[TB] FAIL zero_len_width: got %0d required 1", runLen);
                end
                runLen = 0;
            end
            prev = cur;
        end
        checks++;
        if ({lfsr_state, pulse, pulse_cnt} !== expVec()) begin
            errors++;
            $display("[TB] FAIL zero_len_model: got %h required %h", {lfsr_state, pulse, pulse_cnt}, expVec());
        end
    endtask

    task automatic test_raw_rate();
        int hits [NCH];
        int diff [NCH];
        bit diverged = 0;
        enable = 1'b1; thresh = 32'h80808080;
        repeat (10) tick();
        mode = 1'b0;
        for (int i = 0; i < NCH; i++) begin hits[i] = 0; diff[i] = 0; end
        for (int c = 0; c < 20000; c++) begin
            tick();
            if (!diverged) begin
                checks++;
                if ({lfsr_state, pulse, pulse_cnt} !== expVec()) begin
                    errors++; diverged = 1;
                    $display("[TB] FAIL raw_model_cycle%0d: got %h required %h",
                             c, {lfsr_state, pulse, pulse_cnt}, expVec());
                end
            end
            for (int i = 0; i < NCH; i++) begin
                hits[i] += int'(pulse[i]);
                if (pulse[i] !== pulse[0]) diff[i]++;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            checks++;
            if (hits[i] < 9000 || hits[i] > 11000) begin
                errors++;
                $display("[TB] FAIL raw_rate_ch%0d: got %0d hits required 9000..11000", i, hits[i]);
            end
            if (i > 0) begin
                checks++;
                if (diff[i] == 0) begin
                    errors++;
                    $display("[TB] FAIL raw_distinct_ch%0d: got identical to ch0 required different", i);
                end
            end
        end
    endtask

    task automatic test_saturation_clear();
        bit h0;
        bit diverged = 0;
        mode = 1'b0; thresh = '1; enable = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (!diverged) begin
                checks++;
                if ({lfsr_state, pulse, pulse_cnt} !== expVec()) begin
                    errors++; diverged = 1;
                    $display("[TB] FAIL sat_model_cycle%0d: got %h required %h",
                             c, {lfsr_state, pulse, pulse_cnt}, expVec());
                end
            end
        end
        for (int i = 0; i < NCH; i++) begin
            checks++;
            if (pulse_cnt[i*4 +: 4] !== 4'hF) begin
                errors++;
                $display("[TB] FAIL saturate_ch%0d: got %h required f", i, pulse_cnt[i*4 +: 4]);
            end
        end
        cnt_clear = 1'b1;
        h0 = modelHit(0);
        tick();
        cnt_clear = 1'b0;
        checks++;
        if (pulse_cnt[3:0] !== (h0 ? 4'd1 : 4'd0)) begin
            errors++;
            $display("[TB] FAIL clear_with_trigger: got %h required %h", pulse_cnt[3:0], (h0 ? 4'd1 : 4'd0));
        end
        checks++;
        if ({lfsr_state, pulse, pulse_cnt} !== expVec()) begin
            errors++;
            $display("[TB] FAIL clear_model: got %h required %h", {lfsr_state, pulse, pulse_cnt}, expVec());
        end
    endtask

    task automatic test_reset_mid_high();
        int n = 0;
        mode = 1'b1; thresh = 32'h000000FF; pulse_len = 8'd20; dead_time = 8'd1; enable = 1'b1;
        repeat (4) tick();
        while (pulse[0] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (pulse[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_high_wait: got no pulse within 50 cycles required pulse");
        end
        repeat (3) tick();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({lfsr_state, pulse, pulse_cnt} !== {SEED_M, 4'h0, 16'h0}) begin
            errors++;
            $display("[TB] FAIL reset_mid_high: got %h required %h",
                     {lfsr_state, pulse, pulse_cnt}, {SEED_M, 4'h0, 16'h0});
        end
        modelReset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random();
        bit diverged = 0;
        for (int c = 0; c < 3000; c++) begin
            applyStimulus();
            tick();
            if (!diverged) begin
                checks++;
                if ({lfsr_state, pulse, pulse_cnt} !== expVec()) begin
                    errors++; diverged = 1;
                    $display("[TB] FAIL random_cycle%0d: got %h required %h",
                             c, {lfsr_state, pulse, pulse_cnt}, expVec());
                end
            end
        end
        seed_load = 1'b0; cnt_clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lfsr_check();
        test_seed_load();
        test_zero_thresh();
        test_shaped();
        test_raw_rate();
        test_saturation_clear();
        test_reset_mid_high();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
